rom_seq_reader: RTL

- Initiator side of the 8-bit lookup-table read interface used by the speech-processing tables.
- Walks a contiguous run of table addresses, starting at a programmable base and wrapping modulo 256.
- Drives the table address, captures the registered table output after the fixed read latency, and forwards entries in order on a valid/ready stream with a last marker.
- Contains a small credit-controlled skid FIFO, so downstream backpressure never drops table data. The table itself has no stall input.

---
 rtl/rom_rd_pkg.sv | 20 ++
 rtl/rom_seq_reader_if.sv | 27 ++
 rtl/rom_rd_skid_fifo.sv | 54 +++++
 rtl/rom_seq_reader.sv | 128 ++++++++++++
 4 files changed

// File: rtl/rom_rd_pkg.sv
// Shared definitions for the sequential lookup-table reader: table geometry,
// FSM states and the width helper for credit/occupancy counters.
package rom_rd_pkg;

  localparam int TBL_AW = 8;
  localparam int TBL_DW = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_e;

  // Counter width able to hold 0..depth inclusive.
  function automatic int credit_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/rom_seq_reader_if.sv
// Table read bus plus the outgoing valid/ready stream of the reader.
interface rom_seq_reader_if
  import rom_rd_pkg::*;
#(
  parameter int AW = TBL_AW,
  parameter int DW = TBL_DW
);

  logic [AW-1:0] add;
  logic          rd_en;
  logic [DW-1:0] Bop;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          dout_last;

  modport master (
    output add, rd_en, dout, dout_valid, dout_last,
    input  Bop, dout_ready
  );

  modport slave (
    input  add, rd_en, dout, dout_valid, dout_last,
    output Bop, dout_ready
  );

endinterface

// File: rtl/rom_rd_skid_fifo.sv
// First-word-fall-through FIFO holding {last, data}; head is visible while not empty.
module rom_rd_skid_fifo
  import rom_rd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 9
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [W-1:0]               push_data_i,
  input  logic                       pop_i,
  output logic [W-1:0]               head_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [credit_w(DEPTH)-1:0] occ_o
);

  localparam int CW = credit_w(DEPTH);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] occ_q;
  logic          pop_ok;
  logic          push_ok;

  assign empty_o = (occ_q == '0);
  assign full_o  = (occ_q == CW'(DEPTH));
  assign occ_o   = occ_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      occ_q <= occ_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/rom_seq_reader.sv
// Walks a wrapping run of table addresses, realigns the registered table output
// and forwards it in order on a stream, never issuing more reads than it can buffer.
module rom_seq_reader
  import rom_rd_pkg::*;
#(
  parameter int ROM_LAT    = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int AW         = TBL_AW,
  parameter int DW         = TBL_DW
) (
  input  logic             CS,
  input  logic             cen,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [AW:0]      count,
  output logic             busy,
  output logic             done,
  rom_seq_reader_if.master bus
);

  localparam int            CW      = credit_w(FIFO_DEPTH);
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(FIFO_DEPTH);

  rd_state_e     state_q, state_d;
  logic [AW-1:0] next_addr_q;
  logic [AW-1:0] add_q;
  logic [AW:0]   remaining_q;
  logic [CW-1:0] inflight_q;
  logic [ROM_LAT:0] pipe_v_q;
  logic [ROM_LAT:0] pipe_l_q;

  logic          issue;
  logic          last_issue;
  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic          fifo_full;
  logic [CW-1:0] fifo_occ;
  logic [DW:0]   fifo_head;

  assign last_issue = (remaining_q == (AW+1)'(1));
  assign push       = pipe_v_q[ROM_LAT];
  assign pop        = !fifo_empty && bus.dout_ready;

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = (count != '0) ? ISSUE : DONE;
      end
      ISSUE: begin
        // Credit check uses registered occupancy; a same-cycle pop frees space next cycle.
        issue = ({1'b0, fifo_occ} + {1'b0, inflight_q}) < DEPTH_C;
        if (issue && last_issue) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && fifo_head[DW] && (inflight_q == '0) && (fifo_occ == CW'(1)))
          state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CS) begin
    if (!cen) begin
      state_q     <= IDLE;
      next_addr_q <= '0;
      add_q       <= '0;
      remaining_q <= '0;
      inflight_q  <= '0;
      pipe_v_q    <= '0;
      pipe_l_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        next_addr_q <= base_addr;
        remaining_q <= count;
      end
      if (issue) begin
        add_q       <= next_addr_q;
        next_addr_q <= next_addr_q + 1'b1;
        remaining_q <= remaining_q - 1'b1;
      end
      inflight_q  <= inflight_q + CW'(issue) - CW'(push);
      pipe_v_q[0] <= issue;
      pipe_l_q[0] <= issue && last_issue;
      // Tags travel alongside the table's read latency so data and marker line up.
      for (int i = 1; i <= ROM_LAT; i++) begin
        pipe_v_q[i] <= pipe_v_q[i-1];
        pipe_l_q[i] <= pipe_l_q[i-1];
      end
    end
  end

  rom_rd_skid_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DW + 1)
  ) u_fifo (
    .clk         (CS),
    .rst_n       (cen),
    .push_i      (push),
    .push_data_i ({pipe_l_q[ROM_LAT], bus.Bop}),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .occ_o       (fifo_occ)
  );

`ifndef SYNTHESIS
  always_ff @(posedge CS) begin
    if (cen) assert (!(push && fifo_full && !pop))
      else $error("rom_seq_reader: skid FIFO overflow");
  end
`endif

  assign bus.add        = add_q;
  assign bus.rd_en      = pipe_v_q[0];
  assign bus.dout       = fifo_head[DW-1:0];
  assign bus.dout_valid = !fifo_empty;
  assign bus.dout_last  = fifo_head[DW] && !fifo_empty;

  assign busy = (state_q == ISSUE) || (state_q == DRAIN);
  assign done = (state_q == DONE);

endmodule
